junta_digitos: RTL
==================

# junta_digitos

Sequential BCD-to-binary converter: accepts a packed word of decimal digits and produces the equivalent unsigned 32-bit binary value. It is the inverse of the digit-split path that feeds the seven-segment display. It sits between the keypad/switch digit entry and the MIPS data path, for example to load a typed decimal constant into a register. It processes one digit per clock, most significant digit first, using a start/busy/done handshake.

## Interface
- N_DIGITOS, 8, number of BCD digits converted; legal range 1..9, since 10^9-1 fits in 32 bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- digitos  in  4*N_DIGITOS  packed BCD; [3:0] = ones, [7:4] = tens, ..., top nibble = most significant digit.
- value  out  32  binary result; holds the last completed result.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when value has just been updated.
- erro  out  1  invalid-digit flag; valid while done is high, then holds until the next done (see Configuration).

## Operation
- States: IDLE, ACUM.
- IDLE:
  - On a clock edge with start=1, capture digitos into an internal shift register.
  - Clear the accumulator and the digit counter.
  - Go to ACUM.
- ACUM, each edge:
  - acc <= acc*10 + top nibble of the shift register.
  - Implement the multiply as (acc<<3)+(acc<<1); arithmetic is unsigned 32-bit, modulo 2^32.
  - Shift the shift register left 4 bits and increment the counter.
- On the edge that consumes digit N_DIGITOS:
  - value <= final acc.
  - done <= 1 for exactly one cycle.
  - State returns to IDLE.
- start while busy=1 is ignored; it is neither queued nor restarted.
- digitos changes after the capture edge do not affect the running conversion.
- start=1 in the cycle where done=1 is accepted (state is IDLE), so back-to-back conversions complete every N_DIGITOS+1 cycles.
- Holding start high continuously repeats conversions back to back.

## Timing
- Reset values: state=IDLE, value=0, busy=0, done=0, erro=0, accumulator=0, counter=0.
- start sampled high at edge E:
  - busy=1 from after E through edge E+N_DIGITOS.
  - value/done/erro update at edge E+N_DIGITOS; busy falls at that same edge.
  - Latency from start to done = N_DIGITOS cycles; done is high during the cycle after E+N_DIGITOS.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-conversion: immediate abort, all outputs return to reset values, and no done pulse follows.
- value is stable except at the done edge.

## Configuration
- JUNTA_DIGITOS_CHECK_EN defined:
  - At the capture edge, each nibble is checked for a value >9, and the result is registered.
  - If any nibble is >9, the completion edge sets erro=1 and value=0.
  - Otherwise erro=0 and value is the normal result.
  - Latency is unchanged.
- Not defined:
  - No check logic is built; erro is tied 0.
  - Nibbles >9 are used arithmetically as-is (e.g. 0xA weighs as 10).

## Test plan
- Reset then idle, start=0 for 20 cycles -> value=0, busy=0, done=0 throughout.
- digitos=0x12345678, 1-cycle start -> busy for 8 cycles; done pulse with value=0x00BC614E (12345678).
- digitos=0x99999999 and then 0x00000000, back to back with start held high -> done pulses 9 cycles apart; value=0x05F5E0FF, then 0x00000000.
- Conversion of 0x00000042 running; start pulsed with 0x11111111 at cycles 3 and 5 -> ignored; single done with value=42.
- rst_n pulsed low at cycle 4 of a 0x87654321 conversion -> outputs zero immediately, no done; a new start afterwards yields value=87654321.
- digitos=0x0000A123:
  - with JUNTA_DIGITOS_CHECK_EN -> done with erro=1, value=0.
  - without it -> erro=0, value=10123.

Source files
------------

// File: rtl/junta_digitos.sv
// junta_digitos: sequential packed-BCD to 32-bit binary converter.
// It consumes one decimal digit per clock, most significant digit first:
// acc <= acc*10 + digit.
//
// Handshake: start is sampled only in IDLE. busy is high for the
// N_DIGITOS cycles of a conversion. done is a one-cycle pulse on the
// cycle after value is updated. start while busy is dropped; it is not
// queued. start held high repeats conversions every N_DIGITOS+1 cycles.
//
// Optional feature, macro JUNTA_DIGITOS_CHECK_EN:
//   Defined     - nibbles > 9 are flagged at capture. The completion
//                 edge then reports erro=1 with value=0.
//   Not defined - no check logic is built and erro is tied 0. Nibbles
//                 > 9 weigh arithmetically as-is (0xA counts as 10).
//
// estado_dbg exposes the FSM state: 0 = IDLE, 1 = ACUM.
module junta_digitos #(
  parameter int N_DIGITOS = 8  // legal range 1..9 (10^9-1 fits in 32 bits)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*N_DIGITOS-1:0] digitos,
  output logic [31:0]            value,
  output logic                   busy,
  output logic                   done,
  output logic                   erro,
  output logic                   estado_dbg
);

  localparam int         W      = 4 * N_DIGITOS;
  localparam logic [3:0] ULTIMO = 4'(N_DIGITOS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ACUM = 1'b1
  } estado_t;

  estado_t     state, state_d;
  logic [W-1:0] sr, sr_d;
  logic [31:0] acc, acc_d;
  logic [31:0] acc_mac;
  logic [3:0]  cnt, cnt_d;
  logic [31:0] value_d;
  logic        busy_d;
  logic        done_d;
  logic        captura;   // start accepted on this edge
  logic        fim;       // this edge consumes the last digit
  logic        descarta;  // the running word contained an invalid digit

  assign captura    = (state == IDLE) && start;
  assign fim        = (state == ACUM) && (cnt == ULTIMO);
  assign estado_dbg = state;

`ifdef JUNTA_DIGITOS_CHECK_EN
  logic bad_q, bad_d;
  logic erro_q, erro_d;

  // Flag nibbles > 9 at capture; report the flag at the completion edge.
  always_comb begin
    bad_d  = bad_q;
    erro_d = erro_q;
    if (captura) begin
      bad_d = 1'b0;
      for (int i = 0; i < N_DIGITOS; i++) begin
        if (digitos[4*i +: 4] > 4'd9) bad_d = 1'b1;
      end
    end
    if (fim) erro_d = bad_q;
  end

  // Register the invalid-digit flag and the error output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q  <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      bad_q  <= bad_d;
      erro_q <= erro_d;
    end
  end

  assign erro     = erro_q;
  assign descarta = bad_q;
`else
  assign erro     = 1'b0;
  assign descarta = 1'b0;
`endif

  // Next state, datapath and output values.
  always_comb begin
    state_d = state;
    sr_d    = sr;
    acc_d   = acc;
    cnt_d   = cnt;
    value_d = value;
    busy_d  = busy;
    done_d  = 1'b0;
    // Multiply by ten as (acc<<3)+(acc<<1); wraps modulo 2^32.
    acc_mac = (acc << 3) + (acc << 1) + {28'd0, sr[W-1 -: 4]};
    case (state)
      IDLE: begin
        if (start) begin
          state_d = ACUM;
          sr_d    = digitos;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ACUM: begin
        acc_d = acc_mac;
        sr_d  = sr << 4;
        cnt_d = cnt + 4'd1;
        if (cnt == ULTIMO) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          value_d = descarta ? 32'd0 : acc_mac;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Register the state, the datapath and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      value <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      sr    <= sr_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      value <= value_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

endmodule
